alu_status_unit: RTL and testbench

Registered result/status stage that sits directly downstream of the 6-bit ALU datapath and its `overflow` detector. It captures each ALU result together with `OVERFLOW_FLAG` through a valid/ready handshake and derives N/Z/V flags. It keeps a sticky overflow bit and a saturating overflow-event counter, then presents one registered result word to the consumer (register file / display). It holds the word until the consumer takes it, so back-pressure never loses an ALU result.

---
 rtl/alu_status_unit.sv | 120 ++++++++++++
 tb/tb_alu_status_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_status_unit.sv
// Registered result/status stage behind the ALU: N/Z/V flags, sticky overflow, event counter.
// Define ALU_SATURATE_EN to clamp overflowed add/sub results to the signed limit.
module alu_status_unit #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] RESULT,
    input  logic [2:0]       ADD_SUB,
    input  logic             OVERFLOW_FLAG,
    input  logic             CLEAR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_RESULT,
    output logic             FLAG_N,
    output logic             FLAG_Z,
    output logic             FLAG_V,
    output logic             OVF_STICKY,
    output logic [CNT_W-1:0] OVF_COUNT
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             v;
    logic [WIDTH-1:0] res_sel;
    logic [CNT_W-1:0] cnt_base;
    logic             unused_a;

    assign IN_READY = (state_q == EMPTY) || OUT_READY;
    assign accept   = IN_VALID && IN_READY;
    assign v        = OVERFLOW_FLAG && ((ADD_SUB == 3'b000) || (ADD_SUB == 3'b001));
    assign unused_a = ^A;

`ifdef ALU_SATURATE_EN
    // Operand A's sign is the true sign of an overflowed add/sub.
    always_comb begin
        res_sel = RESULT;
        if (v) begin
            res_sel = A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    always_comb begin
        res_sel = RESULT;
    end
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        n_d     = n_q;
        z_d     = z_q;
        v_d     = v_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (OUT_READY) state_d = accept ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            res_d = res_sel;
            n_d   = res_sel[WIDTH-1];
            z_d   = (res_sel == '0);
            v_d   = v;
        end
    end

    // CLEAR wipes the old count, but a same-cycle overflow still counts.
    always_comb begin
        cnt_base = CLEAR ? '0 : cnt_q;
        cnt_d    = cnt_base;
        sticky_d = CLEAR ? 1'b0 : sticky_q;
        if (accept && v) begin
            sticky_d = 1'b1;
            if (cnt_base != '1) cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            res_q    <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            n_q      <= n_d;
            z_q      <= z_d;
            v_q      <= v_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign OUT_VALID  = (state_q == FULL);
    assign OUT_RESULT = res_q;
    assign FLAG_N     = n_q;
    assign FLAG_Z     = z_q;
    assign FLAG_V     = v_q;
    assign OVF_STICKY = sticky_q;
    assign OVF_COUNT  = cnt_q;

endmodule

// File: tb/tb_alu_status_unit.sv
// Directed bench for alu_status_unit: handshake, flags, saturation, counter, async reset.
module tb_alu_status_unit;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       IN_VALID;
    logic       IN_READY;
    logic [5:0] A;
    logic [5:0] RESULT;
    logic [2:0] ADD_SUB;
    logic       OVERFLOW_FLAG;
    logic       CLEAR;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [5:0] OUT_RESULT;
    logic       FLAG_N;
    logic       FLAG_Z;
    logic       FLAG_V;
    logic       OVF_STICKY;
    logic [7:0] OVF_COUNT;

    int checks = 0;
    int errors = 0;

    alu_status_unit #(.WIDTH(6), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .RESULT(RESULT), .ADD_SUB(ADD_SUB),
        .OVERFLOW_FLAG(OVERFLOW_FLAG), .CLEAR(CLEAR),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_RESULT(OUT_RESULT),
        .FLAG_N(FLAG_N), .FLAG_Z(FLAG_Z), .FLAG_V(FLAG_V),
        .OVF_STICKY(OVF_STICKY), .OVF_COUNT(OVF_COUNT)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [5:0] a,
                         input logic [5:0] r, input logic [2:0] op,
                         input logic ovf);
        IN_VALID      = vld;
        A             = a;
        RESULT        = r;
        ADD_SUB       = op;
        OVERFLOW_FLAG = ovf;
    endtask

    initial begin
        reset_n   = 1'b0;
        CLEAR     = 1'b0;
        OUT_READY = 1'b1;
        drive(1'b0, 6'd0, 6'd0, 3'b000, 1'b0);
        step();
        step();
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_result", OUT_RESULT, 0);
        chk("rst_nzv", {FLAG_N, FLAG_Z, FLAG_V}, 0);
        chk("rst_sticky", OVF_STICKY, 0);
        chk("rst_count", OVF_COUNT, 0);
        chk("rst_in_ready", IN_READY, 1);
        #2 reset_n = 1'b1;
        step();

        // 17 + -19, no overflow
        drive(1'b1, 6'b010001, 6'b111110, 3'b000, 1'b0);
        step();
        chk("v1_valid", OUT_VALID, 1);
        chk("v1_result", OUT_RESULT, 6'b111110);
        chk("v1_nzv", {FLAG_N, FLAG_Z, FLAG_V}, 3'b100);
        chk("v1_count", OVF_COUNT, 0);

        // 17 + 19, positive overflow
        drive(1'b1, 6'b010001, 6'b100100, 3'b000, 1'b1);
        step();
`ifdef ALU_SATURATE_EN
        chk("v2_result", OUT_RESULT, 6'b011111);
        chk("v2_n", FLAG_N, 0);
`else
        chk("v2_result", OUT_RESULT, 6'b100100);
        chk("v2_n", FLAG_N, 1);
`endif
        chk("v2_v", FLAG_V, 1);
        chk("v2_sticky", OVF_STICKY, 1);
        chk("v2_count", OVF_COUNT, 1);

        // -17 + -19, negative overflow
        drive(1'b1, 6'b101111, 6'b011100, 3'b001, 1'b1);
        step();
`ifdef ALU_SATURATE_EN
        chk("v3_result", OUT_RESULT, 6'b100000);
        chk("v3_n", FLAG_N, 1);
`else
        chk("v3_result", OUT_RESULT, 6'b011100);
        chk("v3_n", FLAG_N, 0);
`endif
        chk("v3_zv", {FLAG_Z, FLAG_V}, 2'b01);
        chk("v3_count", OVF_COUNT, 2);

        // non-arithmetic opcode masks overflow
        drive(1'b1, 6'b101111, 6'b011100, 3'b010, 1'b1);
        step();
        chk("v4_result", OUT_RESULT, 6'b011100);
        chk("v4_nzv", {FLAG_N, FLAG_Z, FLAG_V}, 3'b000);
        chk("v4_count", OVF_COUNT, 2);
        chk("v4_sticky", OVF_STICKY, 1);

        drive(1'b1, 6'b000011, 6'b000000, 3'b000, 1'b0);
        step();
        chk("zero_nzv", {FLAG_N, FLAG_Z, FLAG_V}, 3'b010);

        drive(1'b0, 6'd0, 6'd0, 3'b000, 1'b0);
        step();
        chk("drain_valid", OUT_VALID, 0);

        // back-pressure: first word held, second waits
        OUT_READY = 1'b0;
        drive(1'b1, 6'd0, 6'b000101, 3'b000, 1'b0);
        step();
        chk("stall_load", OUT_RESULT, 6'b000101);
        drive(1'b1, 6'd0, 6'b001010, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_in_ready", IN_READY, 0);
            chk("stall_result", OUT_RESULT, 6'b000101);
            chk("stall_valid", OUT_VALID, 1);
            chk("stall_count", OVF_COUNT, 2);
        end
        OUT_READY = 1'b1;
        #1;
        chk("release_in_ready", IN_READY, 1);
        step();
        chk("release_result", OUT_RESULT, 6'b001010);
        chk("release_v", FLAG_V, 1);
        chk("release_count", OVF_COUNT, 3);
        drive(1'b0, 6'd0, 6'd0, 3'b000, 1'b0);
        step();
        chk("no_dup_valid", OUT_VALID, 0);
        chk("no_dup_count", OVF_COUNT, 3);

        // saturating counter
        drive(1'b1, 6'b010001, 6'b100100, 3'b000, 1'b1);
        for (int i = 0; i < 260; i++) step();
        chk("sat_count", OVF_COUNT, 255);
        chk("sat_sticky", OVF_STICKY, 1);

        CLEAR = 1'b1;
        step();
        chk("clr_ovf_count", OVF_COUNT, 1);
        chk("clr_ovf_sticky", OVF_STICKY, 1);
        drive(1'b0, 6'd0, 6'd0, 3'b000, 1'b0);
        step();
        chk("clr_count", OVF_COUNT, 0);
        chk("clr_sticky", OVF_STICKY, 0);
        CLEAR = 1'b0;

        // async reset while full and stalled
        drive(1'b1, 6'b010001, 6'b100100, 3'b000, 1'b1);
        step();
        OUT_READY = 1'b0;
        step();
        chk("pre_rst_valid", OUT_VALID, 1);
        chk("pre_rst_count", OVF_COUNT, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", OUT_VALID, 0);
        chk("arst_result", OUT_RESULT, 0);
        chk("arst_nzv", {FLAG_N, FLAG_Z, FLAG_V}, 0);
        chk("arst_sticky", OVF_STICKY, 0);
        chk("arst_count", OVF_COUNT, 0);
        chk("arst_in_ready", IN_READY, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
